fork_param_sync: RTL

//  Parametric clocked fork: one upstream 4-phase req/ack channel broadcast to
//  `size` downstream 4-phase channels; ack returned only when all enabled branches ack.

---
 rtl/fork_param_sync.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fork_param_sync.sv
// fork_param_sync: clocked 4-phase fork. One upstream req/ack channel is
// broadcast to `size` downstream channels; the upstream ack is returned only
// once every branch enabled at transaction start has acknowledged.
// All handshake inputs arrive asynchronously and pass through synchronisers.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   req_in     upstream request (async)
//   ack_in     upstream acknowledge (registered)
//   req_out    downstream request vector (registered)
//   ack_out    downstream acknowledge vector (async)
//   br_en      branch enable mask, sampled when a transaction starts
//   busy       high whenever the FSM is not idle (registered)
//   txn_count  completed transactions, wraps modulo 2^CNT_W (registered)
module fork_param_sync #(
  parameter int unsigned size        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  output logic             ack_in,
  output logic [size-1:0]  req_out,
  input  logic [size-1:0]  ack_out,
  input  logic [size-1:0]  br_en,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  localparam int unsigned INIT_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_FWD_UP = 3'd2,
    S_ACK_UP = 3'd3,
    S_FWD_DN = 3'd4
  } state_e;

  state_e                           state_q, state_d;
  logic [SYNC_STAGES-1:0]           req_sync_q;
  logic [SYNC_STAGES-1:0][size-1:0] ack_sync_q;
  logic                             req_s;
  logic [size-1:0]                  ack_s;

  logic [size-1:0]   mask_q, mask_d;
  logic [size-1:0]   req_out_q, req_out_d;
  logic              ack_in_q, ack_in_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;

  logic sync_full;
  logic all_acked;
  logic none_acked;

  // Multi-flop synchronisers for the asynchronous handshake inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync_q <= '0;
      ack_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_in};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_out};
    end
  end

  assign req_s = req_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Synchronisers reset to 0, so req_s is only meaningful once the chain has
  // refilled; without this wait a request held across reset would be seen as
  // low and then accepted as a fresh one.
  assign sync_full  = (init_cnt_q == INIT_W'(SYNC_STAGES));
  // Disabled branches count as acked on the way up and as released on the way down
  assign all_acked  = &(ack_s | ~mask_q);
  assign none_acked = ~|(ack_s & mask_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:   if (sync_full && !req_s) state_d = S_IDLE;
      S_IDLE:   if (req_s)               state_d = S_FWD_UP;
      S_FWD_UP: if (all_acked)           state_d = S_ACK_UP;
      S_ACK_UP: if (!req_s)              state_d = S_FWD_DN;
      S_FWD_DN: if (none_acked)          state_d = S_IDLE;
      default:                           state_d = S_INIT;
    endcase
  end

  // Output / datapath next values, all registered below
  always_comb begin
    mask_d     = mask_q;
    req_out_d  = req_out_q;
    ack_in_d   = ack_in_q;
    cnt_d      = cnt_q;
    init_cnt_d = init_cnt_q;
    busy_d     = (state_d != S_IDLE);
    unique case (state_q)
      S_INIT: begin
        if (!sync_full) init_cnt_d = init_cnt_q + INIT_W'(1);
      end
      S_IDLE: begin
        if (req_s) begin
          mask_d    = br_en;
          req_out_d = br_en;
        end
      end
      S_FWD_UP: begin
        if (all_acked) ack_in_d = 1'b1;
      end
      S_ACK_UP: begin
        if (!req_s) req_out_d = '0;
      end
      S_FWD_DN: begin
        if (none_acked) begin
          ack_in_d = 1'b0;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        init_cnt_d = '0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q     <= '0;
      req_out_q  <= '0;
      ack_in_q   <= 1'b0;
      busy_q     <= 1'b1;
      cnt_q      <= '0;
      init_cnt_q <= '0;
    end else begin
      mask_q     <= mask_d;
      req_out_q  <= req_out_d;
      ack_in_q   <= ack_in_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign ack_in    = ack_in_q;
  assign req_out   = req_out_q;
  assign busy      = busy_q;
  assign txn_count = cnt_q;

endmodule
